// File: rtl/gfx_clip.sv
// Pixel clip-and-address stage: drops unset or out-of-rectangle pixels and turns
// the survivors into a single-beat byte-addressed write request.
module gfx_clip #(
  parameter int unsigned point_width = 16,
  parameter int unsigned BPP_LOG2    = 1,
  parameter int unsigned CW          = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   pix_stb_i,
  input  logic                   pix_write_i,
  input  logic [point_width-1:0] pix_x_i,
  input  logic [point_width-1:0] pix_y_i,
  input  logic [CW-1:0]          color_i,
  input  logic                   clip_en_i,
  input  logic [point_width-1:0] clip_x0_i,
  input  logic [point_width-1:0] clip_y0_i,
  input  logic [point_width-1:0] clip_x1_i,
  input  logic [point_width-1:0] clip_y1_i,
  input  logic [point_width-1:0] target_w_i,
  input  logic [point_width-1:0] target_h_i,
  input  logic [31:0]            target_base_i,
  input  logic [15:0]            target_stride_i,
  output logic                   clip_ack_o,
  output logic                   busy_o,
  output logic                   overrun_o,
  output logic                   render_write_o,
  output logic [31:0]            render_adr_o,
  output logic [CW-1:0]          render_dat_o,
  input  logic                   render_ack_i
);

  localparam int unsigned AW = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLIP,
    ADDR,
    WRITE,
    ACK
  } state_t;

  state_t                 state;
  logic [point_width-1:0] x_q;
  logic [point_width-1:0] y_q;
  logic                   set_q;
  logic [CW-1:0]          color_q;

  logic                   inside_c;
  logic [AW-1:0]          adr_c;

  // Inside test against the clip rectangle or the whole target; a degenerate
  // rectangle fails naturally because no x can satisfy x0 <= x < x1.
  always_comb begin
    inside_c = 1'b0;
    if (clip_en_i) begin
      inside_c = (x_q >= clip_x0_i) && (x_q < clip_x1_i) &&
                 (y_q >= clip_y0_i) && (y_q < clip_y1_i);
    end else begin
      inside_c = (x_q < target_w_i) && (y_q < target_h_i);
    end
  end

  // Byte address; product and sum both wrap at 32 bits.
  always_comb begin
    adr_c = target_base_i
          + AW'(AW'(y_q) * AW'(target_stride_i))
          + (AW'(x_q) << BPP_LOG2);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      x_q            <= '0;
      y_q            <= '0;
      set_q          <= 1'b0;
      color_q        <= '0;
      clip_ack_o     <= 1'b0;
      busy_o         <= 1'b0;
      overrun_o      <= 1'b0;
      render_write_o <= 1'b0;
      render_adr_o   <= '0;
      render_dat_o   <= '0;
    end else begin
      clip_ack_o <= 1'b0;
      if (pix_stb_i && (state != IDLE)) begin
        overrun_o <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (pix_stb_i) begin
            x_q     <= pix_x_i;
            y_q     <= pix_y_i;
            set_q   <= pix_write_i;
            color_q <= color_i;
            busy_o  <= 1'b1;
            state   <= CLIP;
          end
        end
        CLIP: begin
          if (!set_q || !inside_c) begin
            clip_ack_o <= 1'b1;
            state      <= ACK;
          end else begin
            state <= ADDR;
          end
        end
        ADDR: begin
          render_adr_o   <= adr_c;
          render_dat_o   <= color_q;
          render_write_o <= 1'b1;
          state          <= WRITE;
        end
        WRITE: begin
          if (render_ack_i) begin
            render_write_o <= 1'b0;
            clip_ack_o     <= 1'b1;
            state          <= ACK;
          end
        end
        ACK: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_o         <= 1'b0;
          render_write_o <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gfx_clip.sv
// Randomised and directed bench for gfx_clip against a behavioural
// clip/address model; timings are observed per cycle on the falling edge.
module tb_gfx_clip;

  logic        clk_i;
  logic        rst_i;
  logic        pix_stb_i;
  logic        pix_write_i;
  logic [15:0] pix_x_i;
  logic [15:0] pix_y_i;
  logic [15:0] color_i;
  logic        clip_en_i;
  logic [15:0] clip_x0_i;
  logic [15:0] clip_y0_i;
  logic [15:0] clip_x1_i;
  logic [15:0] clip_y1_i;
  logic [15:0] target_w_i;
  logic [15:0] target_h_i;
  logic [31:0] target_base_i;
  logic [15:0] target_stride_i;
  logic        clip_ack_o;
  logic        busy_o;
  logic        overrun_o;
  logic        render_write_o;
  logic [31:0] render_adr_o;
  logic [15:0] render_dat_o;
  logic        render_ack_i;

  int errors = 0;
  int checks = 0;

  gfx_clip #(.point_width(16), .BPP_LOG2(1), .CW(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .pix_stb_i(pix_stb_i), .pix_write_i(pix_write_i),
    .pix_x_i(pix_x_i), .pix_y_i(pix_y_i), .color_i(color_i),
    .clip_en_i(clip_en_i),
    .clip_x0_i(clip_x0_i), .clip_y0_i(clip_y0_i),
    .clip_x1_i(clip_x1_i), .clip_y1_i(clip_y1_i),
    .target_w_i(target_w_i), .target_h_i(target_h_i),
    .target_base_i(target_base_i), .target_stride_i(target_stride_i),
    .clip_ack_o(clip_ack_o), .busy_o(busy_o), .overrun_o(overrun_o),
    .render_write_o(render_write_o), .render_adr_o(render_adr_o),
    .render_dat_o(render_dat_o), .render_ack_i(render_ack_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  // Reference model: a pixel survives when set and inside the active region.
  function automatic bit model_keep(input logic [15:0] x, input logic [15:0] y, input logic w);
    int ux, uy;
    ux = int'(x);
    uy = int'(y);
    if (!w) return 1'b0;
    if (clip_en_i)
      return (ux >= int'(clip_x0_i)) && (ux < int'(clip_x1_i)) &&
             (uy >= int'(clip_y0_i)) && (uy < int'(clip_y1_i));
    return (ux < int'(target_w_i)) && (uy < int'(target_h_i));
  endfunction

  function automatic logic [31:0] model_addr(input logic [15:0] x, input logic [15:0] y);
    longint a;
    a = longint'(target_base_i) + longint'(y) * longint'(target_stride_i) + longint'(x) * 2;
    return 32'(a);
  endfunction

  // Presents one pixel and records when things happened (cycle 0 = strobe cycle).
  task automatic send_pixel(input logic [15:0] x, input logic [15:0] y, input logic w,
                            input logic [15:0] col, input int ack_at,
                            output int wr_first, output int wr_last,
                            output int ack_first, output int ack_cnt,
                            output int busy_first, output int busy_last,
                            output logic [31:0] adr, output logic [15:0] dat);
    int n;
    n = ((ack_at > 3) ? ack_at : 3) + 4;
    wr_first = -1; wr_last = -1; ack_first = -1; ack_cnt = 0;
    busy_first = -1; busy_last = -1; adr = '0; dat = '0;
    @(negedge clk_i);
    pix_x_i = x; pix_y_i = y; pix_write_i = w; color_i = col; pix_stb_i = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk_i);
      pix_stb_i = 1'b0;
      if (render_write_o) begin
        if (wr_first < 0) begin
          wr_first = c; adr = render_adr_o; dat = render_dat_o;
        end
        wr_last = c;
      end
      if (clip_ack_o) begin
        ack_cnt++;
        if (ack_first < 0) ack_first = c;
      end
      if (busy_o) begin
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      render_ack_i = (c == ack_at);
    end
    render_ack_i = 1'b0;
  endtask

  task automatic set_clip(input logic en, input logic [15:0] x0, input logic [15:0] x1,
                          input logic [15:0] y0, input logic [15:0] y1);
    clip_en_i = en; clip_x0_i = x0; clip_x1_i = x1; clip_y0_i = y0; clip_y1_i = y1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    pix_stb_i = 1'b0; pix_write_i = 1'b0; pix_x_i = '0; pix_y_i = '0; color_i = '0;
    render_ack_i = 1'b0;
    set_clip(1'b1, 16'd0, 16'd100, 16'd0, 16'd100);
    target_w_i = 16'd320; target_h_i = 16'd200;
    target_base_i = 32'h1000; target_stride_i = 16'd640;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++; if (clip_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", clip_ack_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun_o); end
    checks++; if (render_write_o !== 1'b0) begin errors++; $display("FAIL reset_write: got %b expected 0", render_write_o); end
    checks++; if (render_adr_o !== 32'h0) begin errors++; $display("FAIL reset_adr: got %h expected 0", render_adr_o); end
    checks++; if (render_dat_o !== 16'h0) begin errors++; $display("FAIL reset_dat: got %h expected 0", render_dat_o); end
  endtask

  task automatic test_written_pixel();
    int wf, wl, af, ac, bf, bl;
    logic [31:0] adr;
    logic [15:0] dat;
    set_clip(1'b1, 16'd0, 16'd100, 16'd0, 16'd100);
    target_base_i = 32'h1000; target_stride_i = 16'd640;
    send_pixel(16'd10, 16'd5, 1'b1, 16'hABCD, 5, wf, wl, af, ac, bf, bl, adr, dat);
    checks++; if (adr !== 32'h1C94) begin errors++; $display("FAIL write_adr: got %h expected 1c94", adr); end
    checks++; if (dat !== 16'hABCD) begin errors++; $display("FAIL write_dat: got %h expected abcd", dat); end
    checks++; if (wf !== 3 || wl !== 5) begin errors++; $display("FAIL write_window: got %0d..%0d expected 3..5", wf, wl); end
    checks++; if (af !== 6 || ac !== 1) begin errors++; $display("FAIL write_ack: got cycle %0d count %0d expected cycle 6 count 1", af, ac); end
    checks++; if (bf !== 1 || bl !== 6) begin errors++; $display("FAIL write_busy: got %0d..%0d expected 1..6", bf, bl); end
  endtask

  task automatic test_unset_pixel();
    int wf, wl, af, ac, bf, bl;
    logic [31:0] adr;
    logic [15:0] dat;
    send_pixel(16'd10, 16'd5, 1'b0, 16'h1234, 5, wf, wl, af, ac, bf, bl, adr, dat);
    checks++; if (wf !== -1) begin errors++; $display("FAIL unset_write: got write at cycle %0d expected none", wf); end
    checks++; if (af !== 2 || ac !== 1) begin errors++; $display("FAIL unset_ack: got cycle %0d count %0d expected cycle 2 count 1", af, ac); end
    checks++; if (bf !== 1 || bl !== 2) begin errors++; $display("FAIL unset_busy: got %0d..%0d expected 1..2", bf, bl); end
  endtask

  task automatic test_clip_edges();
    int wf, wl, af, ac, bf, bl;
    logic [31:0] adr;
    logic [15:0] dat;
    logic [15:0] xs [4];
    bit          keep [4];
    xs = '{16'd9, 16'd20, 16'd10, 16'd19};
    keep = '{1'b0, 1'b0, 1'b1, 1'b1};
    set_clip(1'b1, 16'd10, 16'd20, 16'd0, 16'd100);
    for (int i = 0; i < 4; i++) begin
      send_pixel(xs[i], 16'd5, 1'b1, 16'h00F0, 3, wf, wl, af, ac, bf, bl, adr, dat);
      checks++;
      if ((wf >= 0) !== keep[i] || af !== (keep[i] ? 4 : 2)) begin
        errors++;
        $display("FAIL edge_x%0d: got write %0d ack %0d expected write %0b ack %0d",
                 xs[i], wf, af, keep[i], keep[i] ? 4 : 2);
      end
    end
  endtask

  task automatic test_target_and_degenerate();
    int wf, wl, af, ac, bf, bl;
    logic [31:0] adr;
    logic [15:0] dat;
    logic [15:0] xs [4];
    logic [15:0] ys [4];
    bit          keep [4];
    xs = '{16'd319, 16'd320, 16'd0, 16'd50};
    ys = '{16'd199, 16'd0, 16'd200, 16'd50};
    keep = '{1'b1, 1'b0, 1'b0, 1'b0};
    target_w_i = 16'd320; target_h_i = 16'd200;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) set_clip(1'b1, 16'd50, 16'd50, 16'd0, 16'd100);
      else        set_clip(1'b0, 16'd0, 16'd100, 16'd0, 16'd100);
      send_pixel(xs[i], ys[i], 1'b1, 16'h5A5A, 4, wf, wl, af, ac, bf, bl, adr, dat);
      checks++;
      if ((wf >= 0) !== keep[i] || af !== (keep[i] ? 5 : 2)) begin
        errors++;
        $display("FAIL target_%0d_%0d: got write %0d ack %0d expected write %0b ack %0d",
                 xs[i], ys[i], wf, af, keep[i], keep[i] ? 5 : 2);
      end
      if (keep[i]) begin
        checks++;
        if (adr !== model_addr(xs[i], ys[i])) begin
          errors++; $display("FAIL target_adr: got %h expected %h", adr, model_addr(xs[i], ys[i]));
        end
      end
    end
  endtask

  task automatic test_random();
    int wf, wl, af, ac, bf, bl, ack_at;
    logic [31:0] adr;
    logic [15:0] dat, x, y, col;
    logic w;
    bit keep;
    for (int i = 0; i < 40; i++) begin
      set_clip(1'($urandom_range(0, 1)), 16'($urandom_range(0, 40)), 16'($urandom_range(0, 64)),
               16'($urandom_range(0, 40)), 16'($urandom_range(0, 64)));
      target_w_i = 16'($urandom_range(0, 64));
      target_h_i = 16'($urandom_range(0, 64));
      target_base_i = $urandom;
      target_stride_i = 16'($urandom);
      x = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 70));
      y = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 70));
      w = ($urandom_range(0, 4) != 0);
      col = 16'($urandom);
      ack_at = $urandom_range(3, 7);
      keep = model_keep(x, y, w);
      send_pixel(x, y, w, col, ack_at, wf, wl, af, ac, bf, bl, adr, dat);
      checks++;
      if (af !== (keep ? ack_at + 1 : 2) || ac !== 1 || (wf >= 0) !== keep) begin
        errors++;
        $display("FAIL rand%0d_flow: got write %0d ack %0d/%0d expected write %0b ack %0d/1",
                 i, wf, af, ac, keep, keep ? ack_at + 1 : 2);
      end
      if (keep) begin
        checks++;
        if (adr !== model_addr(x, y) || dat !== col || wf !== 3 || wl !== ack_at) begin
          errors++;
          $display("FAIL rand%0d_write: got adr %h dat %h win %0d..%0d expected adr %h dat %h win 3..%0d",
                   i, adr, dat, wf, wl, model_addr(x, y), col, ack_at);
        end
      end
    end
  endtask

  task automatic test_overrun();
    int ac, af;
    logic [31:0] adr;
    logic ovr1, ovr2;
    set_clip(1'b1, 16'd0, 16'd100, 16'd0, 16'd100);
    target_base_i = 32'h1000; target_stride_i = 16'd640;
    ac = 0; af = -1; adr = '0; ovr1 = 1'b0; ovr2 = 1'b0;
    @(negedge clk_i);
    pix_x_i = 16'd12; pix_y_i = 16'd7; pix_write_i = 1'b1; color_i = 16'h0F0F; pix_stb_i = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_i);
      if (c == 1) begin
        ovr1 = overrun_o;
        pix_x_i = 16'd30; pix_y_i = 16'd30; pix_stb_i = 1'b1;
      end else begin
        pix_stb_i = 1'b0;
      end
      if (c == 2) ovr2 = overrun_o;
      if (clip_ack_o) begin ac++; if (af < 0) af = c; end
      if (render_write_o && adr == 32'h0) adr = render_adr_o;
      render_ack_i = (c == 4);
    end
    render_ack_i = 1'b0;
    checks++; if (ovr1 !== 1'b0 || ovr2 !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b,%b expected 0,1", ovr1, ovr2); end
    checks++; if (ac !== 1 || af !== 5) begin errors++; $display("FAIL overrun_ack: got count %0d cycle %0d expected 1 at 5", ac, af); end
    checks++; if (adr !== model_addr(16'd12, 16'd7)) begin errors++; $display("FAIL overrun_adr: got %h expected %h", adr, model_addr(16'd12, 16'd7)); end
    checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", overrun_o); end
  endtask

  task automatic test_reset_in_write();
    int wf, wl, af, ac, bf, bl;
    logic [31:0] adr;
    logic [15:0] dat;
    logic wr4;
    int late_acks;
    wr4 = 1'b0; late_acks = 0;
    @(negedge clk_i);
    pix_x_i = 16'd10; pix_y_i = 16'd5; pix_write_i = 1'b1; color_i = 16'h7777; pix_stb_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_i);
      pix_stb_i = 1'b0;
      if (c == 4) wr4 = render_write_o;
    end
    checks++; if (wr4 !== 1'b1) begin errors++; $display("FAIL rst_pre_write: got %b expected 1", wr4); end
    #1 rst_i = 1'b1;
    #1;
    checks++; if (render_write_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rst_async: got write %b busy %b expected 0 0", render_write_o, busy_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b expected 0", overrun_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    render_ack_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      if (c == 2) render_ack_i = 1'b0;
      if (clip_ack_o || render_write_o) late_acks++;
    end
    checks++; if (late_acks !== 0) begin errors++; $display("FAIL rst_late_ack: got %0d active cycles expected 0", late_acks); end
    send_pixel(16'd11, 16'd6, 1'b1, 16'h4242, 3, wf, wl, af, ac, bf, bl, adr, dat);
    checks++;
    if (af !== 4 || ac !== 1 || adr !== model_addr(16'd11, 16'd6) || dat !== 16'h4242) begin
      errors++;
      $display("FAIL rst_after: got ack %0d/%0d adr %h dat %h expected ack 4/1 adr %h dat 4242",
               af, ac, adr, dat, model_addr(16'd11, 16'd6));
    end
  endtask

  initial begin
    test_reset();
    test_written_pixel();
    test_unset_pixel();
    test_clip_edges();
    test_target_and_degenerate();
    test_random();
    test_overrun();
    test_reset_in_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gfx_clip.md
# gfx_clip

Pixel clip-and-address stage directly downstream of the text blitter. Accepts one pixel position per strobe, discards positions that are unset or fall outside the active clip rectangle, and turns surviving pixels into a single-beat write request (byte address plus colour) for the render/memory write port. Each strobe is answered with exactly one `clip_ack_o` pulse, so the upstream stage can advance.

## Interface
- `point_width`, 16, width of the x/y coordinates and clip bounds.
- `BPP_LOG2`, 1, log2 of bytes per pixel; x is scaled by `<< BPP_LOG2`.
- `CW`, 16, colour width.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `pix_stb_i`  in  1  one-cycle strobe: a pixel position is presented.
- `pix_write_i`  in  1  pixel bit is set; sampled with the strobe.
- `pix_x_i`, `pix_y_i`  in  point_width  pixel coordinates; sampled with the strobe.
- `color_i`  in  CW  foreground colour; sampled with the strobe.
- `clip_en_i`  in  1  1 selects the clip rectangle; 0 selects the full target.
- `clip_x0_i`, `clip_y0_i`  in  point_width  inclusive lower clip bounds.
- `clip_x1_i`, `clip_y1_i`  in  point_width  exclusive upper clip bounds.
- `target_w_i`, `target_h_i`  in  point_width  target size, used when `clip_en_i`=0.
- `target_base_i`  in  32  target base byte address.
- `target_stride_i`  in  16  target line pitch in bytes.
- `clip_ack_o`  out  1  one-cycle pulse: the pixel has been retired.
- `busy_o`  out  1  high whenever the state is not IDLE.
- `overrun_o`  out  1  sticky flag: a strobe arrived while busy.
- `render_write_o`  out  1  write request, held until acknowledged.
- `render_adr_o`  out  32  byte address of the write.
- `render_dat_o`  out  CW  colour to write.
- `render_ack_i`  in  1  write accepted by the downstream port.

## Operation
- States: IDLE, CLIP, ADDR, WRITE, ACK.
- **IDLE**
  - On `pix_stb_i`, capture x, y, write and colour, then go to CLIP.
  - A strobe arriving in any other state is dropped and sets `overrun_o`.
  - `overrun_o` clears only on reset.
- **CLIP**
  - Inside test, all compares unsigned:
    - `clip_en_i`=1: x0 ≤ x < x1 and y0 ≤ y < y1.
    - `clip_en_i`=0: x < `target_w_i` and y < `target_h_i`.
  - Clip and target inputs are sampled in this cycle and must be stable.
  - If the pixel is unset or not inside, go to ACK (discard); otherwise go to ADDR.
  - A degenerate rectangle (x0 ≥ x1 or y0 ≥ y1) discards every pixel.
- **ADDR**
  - Register `render_adr_o` = `target_base_i` + y·`target_stride_i` + (x << BPP_LOG2).
  - The product is a 32-bit unsigned value (coordinates zero-extended, product truncated to 32 bits); the sum wraps modulo 2^32.
  - Register `render_dat_o` from the captured colour.
  - Go to WRITE.
- **WRITE**
  - `render_write_o`=1, with address and data stable.
  - When `render_ack_i` is sampled high, drop `render_write_o` and go to ACK.
- **ACK**
  - `clip_ack_o`=1 for this single cycle, then go to IDLE.
- `render_ack_i` is ignored outside WRITE.

## Timing
- Reset values:
  - State IDLE.
  - `clip_ack_o`, `busy_o`, `overrun_o`, `render_write_o` = 0.
  - `render_adr_o` = 0, `render_dat_o` = 0.
- Cycle numbering: the strobe is sampled in cycle 0.
- Discarded pixel: CLIP in cycle 1, `clip_ack_o` high in cycle 2, IDLE in cycle 3.
- Written pixel:
  - ADDR in cycle 2; `render_write_o` high from cycle 3.
  - If `render_ack_i` is first seen high in cycle k (k ≥ 3), `render_write_o` is low and `clip_ack_o` high in cycle k+1.
  - Minimum strobe-to-ack latency is 4 cycles.
- The next strobe is accepted from cycle 3 (discard) or cycle k+2 (write), i.e. the cycle after the `clip_ack_o` pulse.
- `busy_o` is high from cycle 1 through the ACK cycle.
- Asynchronous reset in any state:
  - Returns to IDLE immediately and clears all outputs.
  - An in-flight write is abandoned with no `clip_ack_o`.
  - A later `render_ack_i` has no effect.

## Test plan
- Set pixel (10,5), clip 0..100 × 0..100, base 0x1000, stride 640, BPP_LOG2=1 -> `render_adr_o`=0x1000+3200+20=0x1C94, `render_write_o` in cycle 3; `render_ack_i` in cycle 5 -> `clip_ack_o` in cycle 6 only.
- Unset pixel (10,5) -> no `render_write_o`; `clip_ack_o` in cycle 2; `busy_o` high in cycles 1-2.
- Edge bounds with clip x0=10, x1=20: x=9 and x=20 discarded (ack cycle 2); x=10 and x=19 written.
- `clip_en_i`=0, target 320×200: (319,199) written; (320,0) and (0,200) discarded; degenerate rectangle x0=x1=50 discards (50,50).
- Strobe in cycle 1 of a pending pixel -> `overrun_o`=1 and sticky; exactly one `clip_ack_o`; `render_adr_o` matches the first pixel.
- Assert `rst_i` during WRITE -> `render_write_o`=0 and state IDLE immediately; a late `render_ack_i` gives no `clip_ack_o`; a new strobe after reset is served normally.
